// File: rtl/axis_user_check.sv
// axis_user_check: checks consecutive tuser sequence numbers and forwards tdata through one register stage
module axis_user_check #(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_WIDTH  = 8,
  parameter int ERROR_WIDTH = 16,
  parameter bit RESYNC      = 1'b1
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic [USER_WIDTH-1:0]  s_tuser,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [USER_WIDTH-1:0]  expected,
  output logic [ERROR_WIDTH-1:0] error_count,
  output logic                   error_flag
);
  logic                   acc, mis, flag_nxt;
  logic [USER_WIDTH-1:0]  exp_base, exp_nxt;
  logic [ERROR_WIDTH-1:0] cnt_base, cnt_nxt;
  assign s_tready = !m_tvalid || m_tready;
  // clear reloads the checker state before the concurrent beat is evaluated
  always_comb begin
    acc      = s_tvalid && s_tready;
    exp_base = clear ? '0 : expected;
    cnt_base = clear ? '0 : error_count;
    mis      = acc && (s_tuser != exp_base);
    exp_nxt  = !acc ? exp_base : (RESYNC && mis) ? s_tuser + USER_WIDTH'(1) : exp_base + USER_WIDTH'(1);
    cnt_nxt  = (mis && !(&cnt_base)) ? cnt_base + ERROR_WIDTH'(1) : cnt_base;
    flag_nxt = (!clear && error_flag) || mis;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      expected    <= '0;
      error_count <= '0;
      error_flag  <= 1'b0;
    end else begin
      if (acc) begin
        m_tdata  <= s_tdata;
        m_tvalid <= 1'b1;
      end else if (m_tready) m_tvalid <= 1'b0;
      expected    <= exp_nxt;
      error_count <= cnt_nxt;
      error_flag  <= flag_nxt;
    end
  end
endmodule

// File: tb/tb_axis_user_check.sv
// tb_axis_user_check: random and directed checks of two checker configurations against a queue/arithmetic model
module tb_axis_user_check;
  logic clk = 0, resetn = 0, clear = 0, s_tvalid = 0, m_tready = 0;
  logic [7:0] s_tdata = 0, s_tuser = 0;
  logic s_tready0, m_tvalid0, error_flag0, s_tready1, m_tvalid1, error_flag1;
  logic [7:0] m_tdata0, expected0, m_tdata1, expected1;
  logic [15:0] error_count0;
  logic [3:0] error_count1;
  int n_assert = 0, n_fail = 0;
  logic [7:0] q[$];
  int exp0 = 0, exp1 = 0, cnt0 = 0, cnt1 = 0;
  bit flag0 = 0, flag1 = 0, last_acc = 0;

  axis_user_check #(.DATA_WIDTH(8), .USER_WIDTH(8), .ERROR_WIDTH(16), .RESYNC(1'b1)) u0 (
    .clock(clk), .resetn(resetn), .clear(clear), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tready(s_tready0), .m_tdata(m_tdata0), .m_tvalid(m_tvalid0),
    .m_tready(m_tready), .expected(expected0), .error_count(error_count0), .error_flag(error_flag0));
  axis_user_check #(.DATA_WIDTH(8), .USER_WIDTH(8), .ERROR_WIDTH(4), .RESYNC(1'b0)) u1 (
    .clock(clk), .resetn(resetn), .clear(clear), .s_tdata(s_tdata), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tready(s_tready1), .m_tdata(m_tdata1), .m_tvalid(m_tvalid1),
    .m_tready(m_tready), .expected(expected1), .error_count(error_count1), .error_flag(error_flag1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp0 = 0; exp1 = 0; cnt0 = 0; cnt1 = 0; flag0 = 0; flag1 = 0;
  endtask

  task automatic check_outputs();
    chk("m_tvalid0", m_tvalid0, q.size() != 0);
    chk("m_tvalid1", m_tvalid1, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_tdata0", m_tdata0, q[0]);
      chk("m_tdata1", m_tdata1, q[0]);
    end
    chk("expected0", expected0, exp0);
    chk("expected1", expected1, exp1);
    chk("error_count0", error_count0, cnt0);
    chk("error_count1", error_count1, cnt1);
    chk("error_flag0", error_flag0, flag0);
    chk("error_flag1", error_flag1, flag1);
  endtask

  task automatic cycle();
    bit acc, stall, m0, m1;
    int b0, b1;
    logic [7:0] held;
    #1;
    chk("s_tready0", s_tready0, q.size() == 0 || m_tready);
    chk("s_tready1", s_tready1, q.size() == 0 || m_tready);
    acc = resetn && s_tvalid && (q.size() == 0 || m_tready);
    stall = q.size() != 0 && !m_tready;
    held = m_tdata0;
    @(posedge clk);
    last_acc = acc;
    if (!resetn) model_reset();
    else begin
      if (q.size() != 0 && m_tready) void'(q.pop_front());
      b0 = clear ? 0 : exp0;
      b1 = clear ? 0 : exp1;
      if (clear) begin cnt0 = 0; cnt1 = 0; flag0 = 0; flag1 = 0; end
      exp0 = b0; exp1 = b1;
      if (acc) begin
        q.push_back(s_tdata);
        m0 = int'(s_tuser) != b0;
        m1 = int'(s_tuser) != b1;
        exp0 = m0 ? (int'(s_tuser) + 1) % 256 : (b0 + 1) % 256;
        exp1 = (b1 + 1) % 256;
        if (m0) begin cnt0 = (cnt0 < 65535) ? cnt0 + 1 : cnt0; flag0 = 1; end
        if (m1) begin cnt1 = (cnt1 < 15) ? cnt1 + 1 : cnt1; flag1 = 1; end
      end
    end
    #1;
    check_outputs();
    if (stall && resetn) chk("stall_stable", m_tdata0, held);
  endtask

  task automatic send(input logic [7:0] tu, input logic [7:0] d);
    int guard = 0;
    s_tvalid = 1; s_tuser = tu; s_tdata = d;
    do begin
      cycle();
      guard++;
    end while (!last_acc && guard < 100);
    if (!last_acc) chk("send_timeout", 0, 1);
    s_tvalid = 0;
  endtask

  task automatic do_clear();
    clear = 1; cycle(); clear = 0;
  endtask

  initial begin
    int sent, cyc;
    logic [7:0] tu;
    // 1: reset values, then 0..9 back-to-back
    repeat (3) cycle();
    chk("rst_m_tdata", m_tdata0, 0);
    chk("rst_expected", expected0, 0);
    resetn = 1; m_tready = 1;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1; s_tuser = 8'(i); s_tdata = 8'(8'h30 + i);
      cycle();
      chk("t1_b2b_accept", last_acc, 1);
    end
    s_tvalid = 0;
    cycle(); cycle();
    chk("t1_expected", expected0, 10);
    chk("t1_count", error_count0, 0);
    // 2: skipped sequence number
    do_clear();
    foreach (q[i]) ;
    begin
      logic [7:0] seq [5] = '{0, 1, 2, 4, 5};
      foreach (seq[i]) send(seq[i], 8'($urandom));
    end
    cycle();
    chk("t2_count_resync", error_count0, 1);
    chk("t2_flag_resync", error_flag0, 1);
    chk("t2_exp_resync", expected0, 6);
    chk("t2_count_noresync", error_count1, 2);
    chk("t2_exp_noresync", expected1, 5);
    // 3: reseed at 254 and wrap through 255 -> 0
    do_clear();
    chk("t3_cleared_flag", error_flag0, 0);
    for (int i = 0; i < 4; i++) send(8'(254 + i), 8'($urandom));
    cycle();
    chk("t3_count", error_count0, 1);
    chk("t3_exp", expected0, 2);
    // 4: random valid and backpressure
    do_clear();
    sent = 0; cyc = 0; tu = 0;
    while (sent < 1000 && cyc < 20000) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tuser = tu; s_tdata = 8'($urandom);
      m_tready = ($urandom_range(0, 2) != 0);
      cycle();
      cyc++;
      if (last_acc) begin sent++; tu++; end
    end
    chk("t4_beats_sent", sent, 1000);
    s_tvalid = 0; m_tready = 1;
    cycle(); cycle();
    chk("t4_count0", error_count0, 0);
    chk("t4_count1", error_count1, 0);
    chk("t4_drained", m_tvalid0, 0);
    // 5: saturation, then clear with a concurrent mismatching beat
    do_clear();
    for (int i = 0; i < 20; i++) send(8'd100, 8'(i));
    cycle();
    chk("t5_sat1", error_count1, 15);
    chk("t5_cnt0", error_count0, 20);
    clear = 1; s_tvalid = 1; s_tuser = 8'd7; s_tdata = 8'hA5;
    cycle();
    chk("t5_clr_acc", last_acc, 1);
    clear = 0; s_tvalid = 0;
    cycle();
    chk("t5_clr_cnt0", error_count0, 1);
    chk("t5_clr_cnt1", error_count1, 1);
    chk("t5_clr_exp0", expected0, 8);
    chk("t5_clr_exp1", expected1, 1);
    // 6: async reset while a beat is stalled
    m_tready = 0;
    send(8'd3, 8'h5C);
    cycle();
    chk("t6_stalled", m_tvalid0, 1);
    resetn = 0;
    #1;
    model_reset();
    chk("t6_async_valid0", m_tvalid0, 0);
    chk("t6_async_valid1", m_tvalid1, 0);
    chk("t6_async_data", m_tdata0, 0);
    chk("t6_async_cnt", error_count0, 0);
    chk("t6_async_flag", error_flag0, 0);
    chk("t6_async_exp", expected0, 0);
    chk("t6_async_ready", s_tready0, 1);
    cycle(); cycle();
    resetn = 1; m_tready = 1;
    for (int i = 0; i < 5; i++) send(8'(i), 8'($urandom));
    cycle();
    chk("t6_resume_cnt", error_count0, 0);
    chk("t6_resume_exp", expected0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
